// File: rtl/bmc_power_cmd_gen.sv
// -----------------------------------------------------------------------------
// bmc_power_cmd_gen
//   Turns BMC power commands into timed, active-low button pulses towards the
//   board CPLD. Optionally verifies that board power-good follows the command.
//   All timing is in units of the 1 ms strobe.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   int_1ms_en     in   one-clock strobe every 1 ms
//   cmd_valid      in   command request, held until accepted
//   cmd_code [2:0] in   1=power_on 2=soft_off 3=force_off 4=reset, others invalid
//   brd_pwrok      in   board power good
//   cmd_ready      out  high only while idle
//   busy           out  high whenever not idle
//   cmd_done       out  one-cycle completion pulse
//   cmd_err        out  one-cycle error flag, coincident with cmd_done
//   bmc_power_out  out  active-low power-button pulse (idle high)
//   bmc_reset_out  out  active-low reset-button pulse (idle high)
//
// Configuration
//   BMC_CMD_STATUS_CHECK_EN  when defined, power-good is checked at accept
//                            time and awaited after the button pulse. When
//                            undefined, brd_pwrok is ignored and the command
//                            completes right after the gap.
// -----------------------------------------------------------------------------
module bmc_power_cmd_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic       int_1ms_en,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_code,
    input  logic       brd_pwrok,
    output logic       cmd_ready,
    output logic       busy,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic       bmc_power_out,
    output logic       bmc_reset_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_GAP,
        S_WAIT_STATUS,
        S_DONE
    } state_t;

    localparam logic [2:0]  CODE_PWR_ON  = 3'd1;
    localparam logic [2:0]  CODE_SOFT    = 3'd2;
    localparam logic [2:0]  CODE_FORCE   = 3'd3;
    localparam logic [2:0]  CODE_RST     = 3'd4;

    localparam logic [16:0] PRESS_SHORT  = 17'd200;
    localparam logic [16:0] PRESS_LONG   = 17'd6000;
    localparam logic [16:0] GAP_LEN      = 17'd100;
`ifdef BMC_CMD_STATUS_CHECK_EN
    localparam logic [16:0] TMO_SOFT     = 17'd70000;
    localparam logic [16:0] TMO_DEFAULT  = 17'd10000;
`endif

    state_t      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [2:0]  code_q, code_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        cmd_done_q, cmd_done_d;
    logic        cmd_err_q, cmd_err_d;
    logic        pwr_out_q, pwr_out_d;
    logic        rst_out_q, rst_out_d;

    logic        fail;
    logic        reject;
    logic        code_bad;
    logic [16:0] press_lim;

    // Nth strobe of the current state: counter already holds N-1.
    function automatic logic last_strobe(input logic en, input logic [16:0] cnt,
                                         input logic [16:0] lim);
        return en && (cnt == lim - 17'd1);
    endfunction

`ifdef BMC_CMD_STATUS_CHECK_EN
    logic        req_pwrok;
    logic [16:0] tmo_lim;
    assign req_pwrok = (code_q == CODE_PWR_ON) || (code_q == CODE_RST);
    assign tmo_lim   = (code_q == CODE_SOFT) ? TMO_SOFT : TMO_DEFAULT;
`else
    logic unused_pwrok;
    assign unused_pwrok = brd_pwrok;
`endif

    assign code_bad  = (cmd_code == 3'd0) || (cmd_code > CODE_RST);
    assign press_lim = (code_q == CODE_FORCE) ? PRESS_LONG : PRESS_SHORT;

`ifdef BMC_CMD_STATUS_CHECK_EN
    // force_off never rejected: it exists to recover a board in any state.
    assign reject = code_bad
                 || ((cmd_code == CODE_PWR_ON) && brd_pwrok)
                 || (((cmd_code == CODE_SOFT) || (cmd_code == CODE_RST)) && !brd_pwrok);
`else
    assign reject = code_bad;
`endif

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fail    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    code_d = cmd_code;
                    if (reject) begin
                        state_d = S_DONE;
                        fail    = 1'b1;
                    end else begin
                        state_d = S_PRESS;
                    end
                end
            end
            S_PRESS: begin
                if (last_strobe(int_1ms_en, cnt_q, press_lim)) state_d = S_GAP;
            end
            S_GAP: begin
                if (last_strobe(int_1ms_en, cnt_q, GAP_LEN)) begin
`ifdef BMC_CMD_STATUS_CHECK_EN
                    state_d = S_WAIT_STATUS;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_WAIT_STATUS: begin
`ifdef BMC_CMD_STATUS_CHECK_EN
                // Status match is tested first so it wins over a same-cycle timeout.
                if (brd_pwrok == req_pwrok) begin
                    state_d = S_DONE;
                end else if (last_strobe(int_1ms_en, cnt_q, tmo_lim)) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end
`else
                state_d = S_DONE;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Single timer: cleared on any state change (so the accept-cycle
        // strobe is never counted), saturating otherwise.
        if (state_d != state_q)
            cnt_d = '0;
        else if (int_1ms_en && (cnt_q != '1))
            cnt_d = cnt_q + 17'd1;
        else
            cnt_d = cnt_q;

        // Outputs are registered from next-state so they line up with the state.
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        cmd_done_d  = (state_d == S_DONE);
        cmd_err_d   = (state_d == S_DONE) && fail;
        pwr_out_d   = !((state_d == S_PRESS) && (code_d != CODE_RST));
        rst_out_d   = !((state_d == S_PRESS) && (code_d == CODE_RST));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            pwr_out_q   <= 1'b1;
            rst_out_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
            pwr_out_q   <= pwr_out_d;
            rst_out_q   <= rst_out_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign cmd_done      = cmd_done_q;
    assign cmd_err       = cmd_err_q;
    assign bmc_power_out = pwr_out_q;
    assign bmc_reset_out = rst_out_q;

endmodule
